// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the sequential multiply-accumulate block.
package mul_seq_pkg;

    // Supported operand widths.
    localparam int LEN_MIN = 2;
    localparam int LEN_MAX = 64;

    // Operation phases: IDLE holds the result, RUN does one shift-add step
    // per cycle, ADD folds the addend into the full-width product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2
    } state_t;

    // Step counter width. One extra bit so the counter can hold LEN itself.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

    // Counter width for the default operand width.
    localparam int CW_DEFAULT = cnt_width(16);

endpackage : mul_seq_pkg

// File: rtl/mul_seq_if.sv
// Operand/result bundle between a requester and the mul_seq block.
interface mul_seq_if #(
    parameter int LEN = 16
) ();

    logic           START;
    logic [LEN-1:0] A;
    logic [LEN-1:0] B;
    logic [LEN-1:0] C;
    logic           DONE;
    logic           BUSY;
    logic [LEN-1:0] P_LO;
    logic [LEN-1:0] P_HI;

    // Requester side: issues operands, observes status and result.
    modport master (
        output START, A, B, C,
        input  DONE, BUSY, P_LO, P_HI
    );

    // Multiplier side: consumes operands, drives status and result.
    modport slave (
        input  START, A, B, C,
        output DONE, BUSY, P_LO, P_HI
    );

endinterface : mul_seq_if

// File: rtl/mul_seq_add_cy.sv
// Plain W-bit ripple adder with carry-in and carry-out.
module add_cy #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Widen by one bit so the carry-out drops out of the same addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule : add_cy

// File: rtl/mul_seq.sv
// Sequential unsigned multiply-accumulate: {P_HI,P_LO} = A*B + C.
// One shift-add step per cycle over LEN cycles, then one cycle to add C.
// A single LEN-bit adder is shared between the RUN and ADD phases.
// DONE/BUSY are registered from the state, so they trail it by one cycle;
// DONE therefore rises LEN+2 edges after the START edge.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int LEN = 16   // operand width, LEN_MIN..LEN_MAX
) (
    input  logic     CLK,
    input  logic     RST_N,
    mul_seq_if.slave bus
);

    localparam int CW = cnt_width(LEN);

    state_t         r_state;
    state_t         w_state_next;

    logic [LEN-1:0] r_p_lo;
    logic [LEN-1:0] r_p_hi;
    logic [LEN-1:0] r_arg_b;
    logic [LEN-1:0] r_arg_c;
    logic [CW-1:0]  r_cnt;
    logic           r_done;

    logic [LEN-1:0] w_add_a;
    logic [LEN-1:0] w_add_b;
    logic [LEN-1:0] w_sum;
    logic           w_cy;
    logic           w_last_step;

    // The step that takes the counter from 1 to 0 is the last RUN cycle.
    assign w_last_step = (r_cnt == CW'(1));

    // Shared adder: P_HI + (P_LO[0] ? argB : 0) in RUN, P_LO + argC in ADD.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_add_a = r_p_hi;
        w_add_b = '0;
        if (r_state == ADD) begin
            w_add_a = r_p_lo;
            w_add_b = r_arg_c;
        end else if (r_p_lo[0]) begin
            w_add_b = r_arg_b;
        end
    end

    add_cy #(
        .W (LEN)
    ) u_add_cy (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cy)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; START restarts from any state.
    always_comb begin
        w_state_next = r_state;
        if (bus.START) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                RUN:     w_state_next = w_last_step ? ADD : RUN;
                ADD:     w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Operand latch and shift-add datapath.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p_lo  <= '0;
            r_p_hi  <= '0;
            r_arg_b <= '0;
            r_arg_c <= '0;
            r_cnt   <= '0;
        end else if (bus.START) begin
            r_p_lo  <= bus.A;
            r_p_hi  <= '0;
            r_arg_b <= bus.B;
            r_arg_c <= bus.C;
            r_cnt   <= CW'(LEN);
        end else begin
            case (r_state)
                RUN: begin
                    // Multiplier bits leave P_LO from the bottom as product
                    // bits enter from the top.
                    {r_p_hi, r_p_lo} <= {w_cy, w_sum, r_p_lo[LEN-1:1]};
                    r_cnt            <= r_cnt - CW'(1);
                end
                ADD: begin
                    // Carry out of the low half ripples into the high half.
                    r_p_lo <= w_sum;
                    r_p_hi <= r_p_hi + {{(LEN-1){1'b0}}, w_cy};
                end
                default: begin
                    r_p_lo <= r_p_lo;
                    r_p_hi <= r_p_hi;
                end
            endcase
        end
    end

    // DONE follows the state one cycle later; it holds high throughout IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_done <= 1'b1;
        end else begin
            r_done <= (r_state == IDLE);
        end
    end

    assign bus.DONE = r_done;
    assign bus.BUSY = ~r_done;
    assign bus.P_LO = r_p_lo;
    assign bus.P_HI = r_p_hi;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (LEN=16): directed cases plus random
// operands compared against an arithmetic A*B+C reference.
module tb_mul_seq;

    localparam int LEN = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mul_seq_if #(.LEN(LEN)) bus ();

    mul_seq #(
        .LEN (LEN)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact unsigned multiply-accumulate.
    function automatic logic [63:0] ref_mac(input logic [LEN-1:0] a,
                                            input logic [LEN-1:0] b,
                                            input logic [LEN-1:0] c);
        return 64'(a) * 64'(b) + 64'(c);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge, then scramble them while busy.
    task automatic do_start(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                            input logic [LEN-1:0] c);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.C     = c;
        bus.START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0;
        bus.A     = LEN'($urandom);
        bus.B     = LEN'($urandom);
        bus.C     = LEN'($urandom);
    endtask

    // Edges from the START edge until DONE is seen high after a low period.
    task automatic wait_done(output int lat, output int low);
        bit seen_low;
        seen_low = 1'b0;
        lat      = 0;
        low      = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("busy_is_not_done", bus.BUSY, !bus.DONE);
            if (bus.DONE && seen_low) begin
                lat = i;
                break;
            end
            if (!bus.DONE) begin
                seen_low = 1'b1;
                low++;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [LEN-1:0] a,
                                input logic [LEN-1:0] b, input logic [LEN-1:0] c);
        logic [63:0] exp;
        exp = ref_mac(a, b, c);
        check({tag, "_p_hi"}, bus.P_HI, exp[2*LEN-1:LEN]);
        check({tag, "_p_lo"}, bus.P_LO, exp[LEN-1:0]);
    endtask

    task automatic run_op(input string tag, input logic [LEN-1:0] a,
                          input logic [LEN-1:0] b, input logic [LEN-1:0] c);
        int lat;
        int low;
        do_start(a, b, c);
        wait_done(lat, low);
        check({tag, "_latency"}, lat, LEN + 2);
        check({tag, "_done_low"}, low, LEN + 1);
        check_result(tag, a, b, c);
    endtask

    initial begin
        logic [LEN-1:0] ra;
        logic [LEN-1:0] rb;
        logic [LEN-1:0] rc;
        logic [LEN-1:0] hold_hi;
        logic [LEN-1:0] hold_lo;
        int             lat;
        int             low;

        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C     = '0;

        // Reset state, with START held high to show it is ignored.
        repeat (2) @(posedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        check("rst_done", bus.DONE, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_p_hi", bus.P_HI, '0);
        check("rst_p_lo", bus.P_LO, '0);
        bus.START = 1'b0;
        rst_n     = 1'b1;

        // Directed cases.
        run_op("small_3x5", 16'd3, 16'd5, 16'd0);

        // Result holds while idle.
        hold_hi = bus.P_HI;
        hold_lo = bus.P_LO;
        repeat (7) @(negedge clk);
        check("idle_hold_done", bus.DONE, 1'b1);
        check("idle_hold_p_hi", bus.P_HI, 16'h0000);
        check("idle_hold_p_lo", bus.P_LO, 16'h000F);
        check("idle_hold_same", {bus.P_HI, bus.P_LO}, {hold_hi, hold_lo});

        run_op("all_ones", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check("all_ones_const", {bus.P_HI, bus.P_LO}, 32'hFFFF_0000);
        run_op("div_trip", 16'd142, 16'd7, 16'd6);
        check("div_trip_const", bus.P_LO, 16'd1000);
        run_op("zero_a", 16'h0000, 16'hFFFF, 16'h00AA);

        // Restart mid-RUN: second START sampled at edge 8 after the first.
        do_start(16'd3, 16'd5, 16'd0);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            check("restart_busy_first", bus.DONE, 1'b0);
        end
        do_start(16'h1234, 16'h0100, 16'h0001);
        wait_done(lat, low);
        check("restart_latency", lat, LEN + 2);
        check("restart_single_done", low, LEN + 1);
        check_result("restart", 16'h1234, 16'h0100, 16'h0001);
        check("restart_const", {bus.P_HI, bus.P_LO}, 32'h0012_3401);

        // Asynchronous reset during RUN cycle 5.
        do_start(16'hBEEF, 16'h1357, 16'h2468);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_done", bus.DONE, 1'b1);
        check("midrst_busy", bus.BUSY, 1'b0);
        check("midrst_p_hi", bus.P_HI, '0);
        check("midrst_p_lo", bus.P_LO, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'd2, 16'd2, 16'd0);
        check("after_rst_const", bus.P_LO, 16'd4);

        // Random operands, occasionally pinned to the extremes.
        for (int i = 0; i < 24; i++) begin
            ra = LEN'($urandom);
            rb = LEN'($urandom);
            rc = LEN'($urandom);
            case ($urandom_range(0, 5))
                0: ra = '1;
                1: rb = '0;
                2: rc = '1;
                default: ;
            endcase
            run_op("random", ra, rb, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mul_seq

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have parameter LEN, default 16, giving the operand width in bits; legal range 2..64.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port START, input, 1 bit: a high level sampled at a CLK edge loads the operands and begins an operation.
REQ-005 The block SHALL have port DONE, output, 1 bit: high when idle and the result is valid.
REQ-006 The block SHALL have port BUSY, output, 1 bit: high while an operation is in progress; always equal to !DONE.
REQ-007 The block SHALL have port A, input, LEN bits: the multiplicand (the quotient, on the rebuild path).
REQ-008 The block SHALL have port B, input, LEN bits: the multiplier (the denominator).
REQ-009 The block SHALL have port C, input, LEN bits: the addend (the remainder).
REQ-010 The block SHALL have port P_LO, output, LEN bits: the low half of A*B+C.
REQ-011 The block SHALL have port P_HI, output, LEN bits: the high half of A*B+C.

Function
REQ-012 The block SHALL compute {P_HI,P_LO} = A*B + C, unsigned and exact; the maximum value (2^LEN-1)^2 + (2^LEN-1) fits in 2*LEN bits, so the result never overflows.
REQ-013 The block SHALL use a three-state FSM: IDLE, RUN and ADD.
REQ-014 START at any state SHALL go to RUN and latch A into P_LO, B into argB and C into argC, and clear P_HI and the step counter to LEN.
REQ-015 START SHALL have priority over all other transitions; a START during RUN or ADD aborts the current operation and restarts it with the new operands.
REQ-016 Each RUN cycle SHALL do the following: if P_LO[0], form {cy,sum} = P_HI + argB (LEN+1 bits), else {cy,sum} = {0,P_HI}; then {P_HI,P_LO} <= {cy,sum,P_LO} >> 1; then decrement the counter.
REQ-017 RUN SHALL go to ADD on the cycle the counter reaches zero, i.e. after exactly LEN RUN cycles.
REQ-018 The single ADD cycle SHALL add argC to the 2*LEN register, propagating the carry from P_LO into P_HI, and then go to IDLE.
REQ-019 DONE SHALL rise exactly LEN+2 rising edges after the edge that sampled START (load, LEN×RUN, ADD).
REQ-020 In IDLE, P_HI, P_LO and DONE SHALL hold unchanged indefinitely.
REQ-021 While BUSY is high, P_HI and P_LO SHALL hold intermediate values that are not meaningful.
REQ-022 The inputs A, B and C SHALL be sampled only on a START edge; changes to them while BUSY have no effect.
REQ-023 Operands of zero SHALL take the same LEN+2 cycle latency; there is no early termination.

Reset
REQ-024 While RST_N is low, the block SHALL asynchronously force the FSM to IDLE, P_HI, P_LO, argB, argC and the counter to 0, DONE to 1 and BUSY to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no partial result retained.
REQ-026 START SHALL be ignored while RST_N is low; the first START is honoured on the first edge after RST_N rises.

Structure
REQ-027 The state encodings IDLE, RUN and ADD and the counter width CW = $clog2(LEN)+1 SHALL be defined in the shared package mul_seq_pkg.
REQ-028 The block SHALL use one sub-module, add_cy, a LEN-bit adder with carry-in and carry-out, used for both the RUN and the ADD additions.
REQ-029 The sub-module SHALL be time-multiplexed by state, with no second adder instance.

Verification (LEN=16)
REQ-030 START with A=3, B=5, C=0 SHALL give DONE low for 17 cycles, then DONE=1 with P_HI=0x0000 and P_LO=0x000F.
REQ-031 START with A=0xFFFF, B=0xFFFF, C=0xFFFF SHALL give P_HI=0xFFFF and P_LO=0x0000.
REQ-032 Divider round trip: START with A=142, B=7, C=6 SHALL give P_LO=1000 (0x03E8) and P_HI=0.
REQ-033 START with A=3, B=5, then a second START at cycle 8 with A=0x1234, B=0x0100, C=1, SHALL give a single DONE 18 cycles after the second START with P_HI=0x0012 and P_LO=0x3401.
REQ-034 RST_N pulsed low at RUN cycle 5 SHALL immediately give DONE=1, P_HI=0 and P_LO=0; a subsequent START with A=2, B=2, C=0 SHALL give P_LO=4.
REQ-035 START with A=0, B=0xFFFF, C=0x00AA SHALL give latency 18 and P_LO=0x00AA, P_HI=0.
